// File: rtl/pipeline_exec_ctrl_pkg.sv
// Shared encodings for the pipeline execution sequencer; the debug unit
// imports the same package so command and state codes stay in lockstep.
package pipeline_exec_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int unsigned DEF_CNT_WIDTH  = 32;
  localparam int unsigned DEF_STEP_WIDTH = 8;

endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// Debug command channel: valid/ready handshake carrying an opcode and a
// step-count argument.
interface pipeline_exec_ctrl_if
  import pipeline_exec_ctrl_pkg::*;
#(
  parameter int unsigned STEP_WIDTH = DEF_STEP_WIDTH
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  cmd_op_e               cmd_op;
  logic [STEP_WIDTH-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             sat
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign sat = &cnt_q;
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !sat) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer for the 5-stage pipeline: run/step/stop/clear control,
// global enable and flush, executed-cycle count, HALT and watchdog detection.
//
// state   | meaning
// ST_IDLE | pipeline frozen, every command accepted
// ST_RUN  | free-running until HALT, watchdog or STOP
// ST_STEP | running for step_cnt_q more cycles, commands held off
// ST_DONE | program ended (HALT or watchdog), only CLEAR leaves
module pipeline_exec_ctrl
  import pipeline_exec_ctrl_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned          STEP_WIDTH = DEF_STEP_WIDTH,
  parameter logic [CNT_WIDTH-1:0] MAX_CYCLES = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_exec_ctrl_if.slave  cmd,
  input  logic                 halt_wb,
  output logic                 pipe_enable,
  output logic                 pipe_flush,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [1:0]           state,
  output logic                 done_pulse,
  output logic                 timeout
);
  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic                  pipe_enable_q, pipe_enable_d;
  logic                  pipe_flush_q, pipe_flush_d;
  logic                  done_pulse_q, done_pulse_d;
  logic                  timeout_q, timeout_d;
  logic                  cmd_ready_c;
  logic                  accept;
  logic                  cnt_clr;
  logic                  cnt_sat;
  logic                  halt_hit;
  logic                  wd_hit;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk (clk),
    .rst (reset),
    .en  (pipe_enable_q),
    .clr (cnt_clr),
    .cnt (cycle_count),
    .sat (cnt_sat)
  );

  // In RUN only STOP is taken; anything else waits on the bus until RUN ends.
  always_comb begin
    cmd_ready_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: cmd_ready_c = 1'b1;
      ST_RUN:           cmd_ready_c = (cmd.cmd_op == CMD_STOP);
      default:          cmd_ready_c = 1'b0;
    endcase
  end

  assign cmd.cmd_ready = cmd_ready_c;
  assign accept        = cmd.cmd_valid && cmd_ready_c;
  assign halt_hit      = pipe_enable_q && halt_wb;
  // Trip when the increment of this enabled cycle lands on MAX_CYCLES.
  assign wd_hit        = pipe_enable_q &&
                         ((cycle_count >= (MAX_CYCLES - CNT_WIDTH'(1))) || cnt_sat);

  always_comb begin
    state_d       = state_q;
    step_cnt_d    = step_cnt_q;
    pipe_enable_d = 1'b0;
    pipe_flush_d  = 1'b0;
    done_pulse_d  = 1'b0;
    timeout_d     = timeout_q;
    cnt_clr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            CMD_RUN: begin
              state_d       = ST_RUN;
              pipe_enable_d = 1'b1;
            end
            CMD_STEP: begin
              state_d       = ST_STEP;
              pipe_enable_d = 1'b1;
              step_cnt_d    = (cmd.cmd_arg == '0) ? STEP_WIDTH'(1) : cmd.cmd_arg;
            end
            CMD_CLEAR: begin
              pipe_flush_d = 1'b1;
              cnt_clr      = 1'b1;
              timeout_d    = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (halt_hit) begin
          state_d      = ST_DONE;
          done_pulse_d = 1'b1;
        end else if (wd_hit) begin
          state_d      = ST_DONE;
          done_pulse_d = 1'b1;
          timeout_d    = 1'b1;
        end else if (accept) begin
          state_d = ST_IDLE;
        end else begin
          pipe_enable_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (halt_hit) begin
          state_d      = ST_DONE;
          done_pulse_d = 1'b1;
          step_cnt_d   = '0;
        end else if (wd_hit) begin
          state_d      = ST_DONE;
          done_pulse_d = 1'b1;
          timeout_d    = 1'b1;
          step_cnt_d   = '0;
        end else if (step_cnt_q <= STEP_WIDTH'(1)) begin
          state_d      = ST_IDLE;
          done_pulse_d = 1'b1;
          step_cnt_d   = '0;
        end else begin
          step_cnt_d    = step_cnt_q - STEP_WIDTH'(1);
          pipe_enable_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (accept && cmd.cmd_op == CMD_CLEAR) begin
          state_d      = ST_IDLE;
          pipe_flush_d = 1'b1;
          cnt_clr      = 1'b1;
          timeout_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      step_cnt_q    <= '0;
      pipe_enable_q <= 1'b0;
      pipe_flush_q  <= 1'b0;
      done_pulse_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_cnt_q    <= step_cnt_d;
      pipe_enable_q <= pipe_enable_d;
      pipe_flush_q  <= pipe_flush_d;
      done_pulse_q  <= done_pulse_d;
      timeout_q     <= timeout_d;
    end
  end

  assign pipe_enable = pipe_enable_q;
  assign pipe_flush  = pipe_flush_q;
  assign done_pulse  = done_pulse_q;
  assign timeout     = timeout_q;
  assign state       = state_q;
endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Scoreboard bench for pipeline_exec_ctrl: episodes are planned by a
// transaction-level model, a monitor checks every enable burst and flush.
module tb_pipeline_exec_ctrl;
  import pipeline_exec_ctrl_pkg::*;

  localparam int MAXC = 20;

  typedef struct {
    bit          flush;
    int          len;
    logic [31:0] cnt;
    logic [1:0]  st;
    logic        to;
    logic        dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt_wb;
  logic        pipe_enable, pipe_flush, done_pulse, timeout;
  logic [31:0] cycle_count;
  logic [1:0]  state;

  pipeline_exec_ctrl_if #(.STEP_WIDTH(8)) cmd_if ();

  pipeline_exec_ctrl #(
    .CNT_WIDTH  (32),
    .STEP_WIDTH (8),
    .MAX_CYCLES (32'd20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd_if),
    .halt_wb     (halt_wb),
    .pipe_enable (pipe_enable),
    .pipe_flush  (pipe_flush),
    .cycle_count (cycle_count),
    .state       (state),
    .done_pulse  (done_pulse),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   m_cnt;
  bit   m_done;
  bit   m_to;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      halt_wb = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    halt_wb = 1'b0;
  endtask

  // Presents a command and waits for the handshake; returns just after the accepting edge.
  task automatic send(input cmd_op_e op, input logic [7:0] arg, input int exp_wait);
    int waited;
    bit acc;
    waited = 0;
    acc    = 1'b0;
    halt_wb = 1'($urandom_range(0, 1));
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    while (!acc && waited < 40) begin
      @(negedge clk);
      acc = cmd_if.cmd_ready;
      @(posedge clk); #1;
      if (!acc) waited++;
    end
    cmd_if.cmd_valid = 1'b0;
    halt_wb = 1'b0;
    chk("cmd_accept_wait", waited, exp_wait);
  endtask

  task automatic do_clear();
    exp_t e;
    e.flush = 1'b1; e.len = 0; e.cnt = 32'd0; e.st = 2'b00; e.to = 1'b0; e.dp = 1'b0;
    q.push_back(e);
    m_cnt = 0; m_to = 1'b0; m_done = 1'b0;
    send(CMD_CLEAR, 8'd0, 0);
    idle(2);
  endtask

  task automatic done_cleanup();
    send(CMD_RUN, 8'd5, 0);
    idle(1);
    if ($urandom_range(0, 1) == 1) begin
      send(cmd_op_e'($urandom_range(2, 3)), 8'($urandom_range(0, 9)), 0);
      idle(1);
    end
    @(negedge clk);
    chk("done_state", state, 2'b11);
    chk("done_timeout", timeout, m_to);
    chk("done_count", cycle_count, m_cnt);
    chk("done_enable", pipe_enable, 1'b0);
    @(posedge clk); #1;
    do_clear();
  endtask

  // h: enabled cycle carrying HALT (0 none); s: enabled cycle issuing STOP (0 none).
  task automatic run_ep(input int h, input int s, input bit junk);
    int   endc;
    int   reason;  // 0 halt, 1 stop, 2 watchdog
    exp_t e;
    endc   = MAXC - m_cnt;
    reason = 2;
    if (s > 0 && s < endc) begin endc = s; reason = 1; end
    if (h > 0 && h <= endc) begin endc = h; reason = 0; end
    e.flush = 1'b0; e.len = endc; e.cnt = 32'(m_cnt + endc);
    e.st = (reason == 1) ? 2'b00 : 2'b11;
    e.to = (reason == 2);
    e.dp = (reason != 1);
    q.push_back(e);
    m_cnt += endc; m_done = (reason != 1); m_to = (reason == 2);
    send(CMD_RUN, 8'd0, 0);
    for (int c = 1; c <= endc; c++) begin
      halt_wb = (c == h);
      if (s > 0 && c == s) begin
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = CMD_STOP;
      end else if (junk && c < endc) begin
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = cmd_op_e'($urandom_range(0, 2));
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (cmd_if.cmd_valid)
        chk((cmd_if.cmd_op == CMD_STOP) ? "run_stop_ready" : "run_hold_ready",
            cmd_if.cmd_ready, (cmd_if.cmd_op == CMD_STOP));
      @(posedge clk); #1;
    end
    halt_wb = 1'b0; cmd_if.cmd_valid = 1'b0;
    idle(2);
    if (m_done) done_cleanup();
  endtask

  task automatic step_ep(input int a, input int h, input bit hold);
    int   endc;
    int   reason;  // 0 halt, 1 complete, 2 watchdog
    exp_t e;
    endc   = (a == 0) ? 1 : a;
    reason = 1;
    if (MAXC - m_cnt <= endc) begin endc = MAXC - m_cnt; reason = 2; end
    if (h > 0 && h <= endc) begin endc = h; reason = 0; end
    e.flush = 1'b0; e.len = endc; e.cnt = 32'(m_cnt + endc);
    e.st = (reason == 1) ? 2'b00 : 2'b11;
    e.to = (reason == 2);
    e.dp = 1'b1;
    q.push_back(e);
    m_cnt += endc; m_done = (reason != 1); m_to = (reason == 2);
    send(CMD_STEP, 8'(a), 0);
    for (int c = 1; c <= endc; c++) begin
      halt_wb = (c == h);
      cmd_if.cmd_valid = hold; cmd_if.cmd_op = CMD_STOP;
      @(negedge clk);
      chk("step_ready", cmd_if.cmd_ready, 1'b0);
      @(posedge clk); #1;
    end
    halt_wb = 1'b0;
    if (hold) begin
      @(negedge clk);
      chk("stop_after_step", cmd_if.cmd_ready, 1'b1);
      @(posedge clk); #1;
    end
    cmd_if.cmd_valid = 1'b0;
    idle(2);
    if (m_done) done_cleanup();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, 2'b00);
    chk({tag, "_enable"}, pipe_enable, 1'b0);
    chk({tag, "_flush"}, pipe_flush, 1'b0);
    chk({tag, "_count"}, cycle_count, 32'd0);
    chk({tag, "_done"}, done_pulse, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_ready"}, cmd_if.cmd_ready, 1'b1);
  endtask

  initial begin : monitor
    int   burst;
    bit   prev_en;
    exp_t e;
    burst   = 0;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        burst = 0; prev_en = 1'b0;
      end else begin
        if (!pipe_enable && prev_en) begin
          checks++;
          if (q.size() == 0 || q[0].flush) begin
            errors++;
            $display("FAIL unexpected_burst: got burst of %0d cycles, expected none", burst);
          end else begin
            e = q.pop_front();
            chk("burst_len", burst, e.len);
            chk("burst_count", cycle_count, e.cnt);
            chk("burst_state", state, e.st);
            chk("burst_timeout", timeout, e.to);
            chk("burst_done_pulse", done_pulse, e.dp);
          end
          burst = 0;
        end else if (done_pulse) begin
          checks++; errors++;
          $display("FAIL stray_done_pulse: got 1 at state %0d, expected 0", state);
        end
        if (pipe_flush) begin
          checks++;
          if (q.size() == 0 || !q[0].flush) begin
            errors++;
            $display("FAIL unexpected_flush: got flush pulse, expected none");
          end else begin
            e = q.pop_front();
            chk("flush_count", cycle_count, e.cnt);
            chk("flush_state", state, e.st);
            chk("flush_timeout", timeout, e.to);
            chk("flush_enable", pipe_enable, 1'b0);
          end
        end
        if (pipe_enable) burst++;
        prev_en = pipe_enable;
      end
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "bench stalled");
  end

  initial begin : stim
    reset = 1'b1;
    halt_wb = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = CMD_CLEAR;
    cmd_if.cmd_arg   = 8'd0;
    m_cnt = 0; m_to = 1'b0; m_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    step_ep(3, 0, 1'b0);
    do_clear();
    run_ep(10, 0, 1'b0);
    run_ep(0, 0, 1'b0);
    run_ep(20, 0, 1'b1);
    run_ep(0, 5, 1'b1);
    step_ep(0, 0, 1'b0);
    step_ep(8, 4, 1'b1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) do_clear();
      if ($urandom_range(0, 1) == 1)
        run_ep(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 22)) : 0,
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 22)) : 0,
               1'($urandom_range(0, 1)));
      else
        step_ep(int'($urandom_range(0, 12)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0,
                1'($urandom_range(0, 1)));
    end

    do_clear();
    send(CMD_RUN, 8'd0, 0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush_in_reset", pipe_flush, 1'b0);
    end
    #2 reset = 1'b0;
    m_cnt = 0; m_to = 1'b0; m_done = 1'b0;
    @(posedge clk); #1;
    step_ep(2, 0, 1'b0);

    idle(3);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
